// File: rtl/prepare_for_fft.sv
// prepare_for_fft
//   Registered gather stage at the front of the FFT datapath. Each output
//   position i takes the input sample selected by new_indices[i]. The
//   upstream stage-ordering logic provides the index map, for example the
//   butterfly pairing 0,8,1,9,... for a 16-point stage. Latency is one
//   cycle and a new frame can be accepted every cycle.
//
// Parameters
//   SAMPLES  frame length, must be a power of two and >= 2
//   WIDTH    bits per sample
//   IDXW     index width, derived as $clog2(SAMPLES)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset; takes priority over in_valid
//   in_valid       input_stream/new_indices carry a frame this cycle
//   input_stream   SAMPLES x WIDTH input samples
//   new_indices    SAMPLES x IDXW source index for each output position
//   out_valid      output_stream holds a permuted frame
//   output_stream  SAMPLES x WIDTH permuted samples (held while idle)
//   perm_error     captured index map was not a permutation
//
// Optional feature
//   PREPARE_FOR_FFT_PERM_CHECK_EN: when defined, perm_error is registered
//   with each captured frame and is set if any source index is absent from
//   the map. When undefined, perm_error is tied to 0 and no check logic
//   exists.

module prepare_for_fft #(
  parameter  int SAMPLES = 16,
  parameter  int WIDTH   = 3,
  localparam int IDXW    = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input_stream  [SAMPLES],
  input  logic [IDXW-1:0]  new_indices   [SAMPLES],
  output logic             out_valid,
  output logic [WIDTH-1:0] output_stream [SAMPLES],
  output logic             perm_error
);

  // Gather network. SAMPLES is a power of two, so every IDXW-bit index
  // addresses a real sample and no range guard is needed.
  logic [WIDTH-1:0] gathered [SAMPLES];

  always_comb begin
    for (int unsigned i = 0; i < unsigned'(SAMPLES); i++) begin
      gathered[i] = input_stream[new_indices[i]];
    end
  end

  // Output register. Data loads only when a frame is accepted, so the
  // outputs keep the last frame while the stage is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(SAMPLES); i++) begin
        output_stream[i] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < unsigned'(SAMPLES); i++) begin
          output_stream[i] <= gathered[i];
        end
      end
    end
  end

`ifdef PREPARE_FOR_FFT_PERM_CHECK_EN
  // Mark every source index that the map references. With SAMPLES entries
  // and SAMPLES possible indices, an unmarked index means a duplicate is
  // present somewhere, so checking for absence is enough.
  logic [SAMPLES-1:0] seen;
  logic               missing;

  always_comb begin
    seen = '0;
    for (int unsigned i = 0; i < unsigned'(SAMPLES); i++) begin
      seen[new_indices[i]] = 1'b1;
    end
    missing = ~&seen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perm_error <= 1'b0;
    end else if (in_valid) begin
      perm_error <= missing;
    end
  end
`else
  assign perm_error = 1'b0;
`endif

endmodule

// File: tb/tb_prepare_for_fft.sv
module tb_prepare_for_fft;

  localparam int N  = 16;
  localparam int W  = 3;
  localparam int IW = 4;

`ifdef PREPARE_FOR_FFT_PERM_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef logic [N-1:0][W-1:0]  frame_t;
  typedef logic [N-1:0][IW-1:0] map_t;

  typedef struct {
    string  name;
    frame_t data;
    map_t   idx;
    frame_t exp;
    logic   exp_perm;
    bit     gap_after;
  } vec_t;

  typedef struct packed {
    frame_t data;
    logic   perm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  input_stream  [N];
  logic [IW-1:0] new_indices   [N];
  logic          out_valid;
  logic [W-1:0]  output_stream [N];
  logic          perm_error;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t sb[$];
  exp_t last_exp;

  prepare_for_fft #(.SAMPLES(N), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .input_stream  (input_stream),
    .new_indices   (new_indices),
    .out_valid     (out_valid),
    .output_stream (output_stream),
    .perm_error    (perm_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: output i is the input selected by map i.
  function automatic frame_t ref_gather(input frame_t d, input map_t m);
    frame_t r;
    for (int i = 0; i < N; i++) r[i] = d[m[i]];
    return r;
  endfunction

  function automatic logic ref_perm_err(input map_t m);
    logic err = 1'b0;
    for (int v = 0; v < N; v++) begin
      bit found = 0;
      for (int i = 0; i < N; i++) if (int'(m[i]) == v) found = 1;
      if (!found) err = 1'b1;
    end
    return CHECK_EN ? err : 1'b0;
  endfunction

  // Drive one cycle of stimulus; the scoreboard gets the expected result
  // only for frames the DUT should accept.
  task automatic drive(input logic r, input logic v, input frame_t d, input map_t m,
                       input frame_t e, input logic ep);
    exp_t x;
    rst      = r;
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      input_stream[i] = d[i];
      new_indices[i]  = m[i];
    end
    if (r) begin
      sb.delete();
      last_exp = '0;
    end else if (v) begin
      x.data = e;
      x.perm = ep;
      sb.push_back(x);
    end
  endtask

  task automatic tick(input string name);
    frame_t act;
    exp_t   x;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) act[i] = output_stream[i];
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({name, ".out_valid"}, 64'(out_valid), 64'(1'b1));
      check({name, ".data"}, 64'(act), 64'(x.data));
      check({name, ".perm_error"}, 64'(perm_error), 64'(x.perm));
      last_exp = x;
    end else begin
      check({name, ".out_valid_idle"}, 64'(out_valid), 64'(1'b0));
      check({name, ".data_held"}, 64'(act), 64'(last_exp.data));
      check({name, ".perm_held"}, 64'(perm_error), 64'(last_exp.perm));
    end
  endtask

  task automatic idle(input string name);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick(name);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'($urandom_range(7));
    return f;
  endfunction

  vec_t vecs[5];

  initial begin
    frame_t ramp, d, e;
    map_t   m;

    for (int i = 0; i < N; i++) ramp[i] = W'(i % 8);

    // Directed table. Expected frames are written from the intended pattern,
    // not from the map.
    vecs[0].name = "butterfly";
    vecs[0].data = ramp;
    for (int i = 0; i < N; i++) begin
      vecs[0].idx[i] = IW'((i % 2 == 0) ? i / 2 : 8 + i / 2);
      vecs[0].exp[i] = W'(i / 2);
    end
    vecs[0].exp_perm  = 1'b0;
    vecs[0].gap_after = 1;

    vecs[1].name = "identity";
    vecs[1].data = ramp;
    for (int i = 0; i < N; i++) begin
      vecs[1].idx[i] = IW'(i);
      vecs[1].exp[i] = W'(i % 8);
    end
    vecs[1].exp_perm  = 1'b0;
    vecs[1].gap_after = 0;

    vecs[2].name = "reversal";
    vecs[2].data = ramp;
    for (int i = 0; i < N; i++) begin
      vecs[2].idx[i] = IW'(15 - i);
      vecs[2].exp[i] = W'(7 - (i % 8));
    end
    vecs[2].exp_perm  = 1'b0;
    vecs[2].gap_after = 1;

    vecs[3].name = "duplicate";
    vecs[3].data = rand_frame();
    vecs[3].data[5] = 3'd6;
    for (int i = 0; i < N; i++) begin
      vecs[3].idx[i] = 4'd5;
      vecs[3].exp[i] = 3'd6;
    end
    vecs[3].exp_perm  = CHECK_EN;
    vecs[3].gap_after = 1;

    vecs[4].name = "pair_swap";
    for (int i = 0; i < N; i++) vecs[4].data[i] = W'((i * 5 + 3) % 8);
    for (int i = 0; i < N; i++) begin
      vecs[4].idx[i] = IW'(i ^ 1);
      vecs[4].exp[i] = W'((((i ^ 1) * 5) + 3) % 8);
    end
    vecs[4].exp_perm  = 1'b0;
    vecs[4].gap_after = 1;

    // Reset with in_valid high and random data: reset must win.
    last_exp = '0;
    for (int c = 0; c < 2; c++) begin
      d = rand_frame();
      for (int i = 0; i < N; i++) m[i] = IW'($urandom_range(15));
      drive(1'b1, 1'b1, d, m, '0, 1'b0);
      tick("reset");
    end

    foreach (vecs[k]) begin
      drive(1'b0, 1'b1, vecs[k].data, vecs[k].idx, vecs[k].exp, vecs[k].exp_perm);
      tick(vecs[k].name);
      if (vecs[k].gap_after) idle({vecs[k].name, "_hold"});
    end

    // Duplicate map followed by idle: perm_error must hold, then a clean map clears it.
    drive(1'b0, 1'b1, vecs[3].data, vecs[3].idx, vecs[3].exp, vecs[3].exp_perm);
    tick("dup_again");
    idle("dup_hold");
    drive(1'b0, 1'b1, vecs[1].data, vecs[1].idx, vecs[1].exp, 1'b0);
    tick("perm_clear");

    // Reset mid-stream: frames A, (B discarded by reset), C.
    d = rand_frame();
    drive(1'b0, 1'b1, d, vecs[2].idx, ref_gather(d, vecs[2].idx), 1'b0);
    tick("mid_a");
    d = rand_frame();
    drive(1'b1, 1'b1, d, vecs[0].idx, '0, 1'b0);
    tick("mid_rst");
    d = rand_frame();
    drive(1'b0, 1'b1, d, vecs[4].idx, ref_gather(d, vecs[4].idx), 1'b0);
    tick("mid_c");
    idle("mid_hold");

    // Random frames with random gaps; half use a shuffled permutation.
    for (int n = 0; n < 40; n++) begin
      d = rand_frame();
      for (int i = 0; i < N; i++) m[i] = IW'(i);
      if ($urandom_range(1) == 0) begin
        for (int i = N - 1; i > 0; i--) begin
          int j = int'($urandom_range(i));
          logic [IW-1:0] t = m[i];
          m[i] = m[j];
          m[j] = t;
        end
      end else begin
        for (int i = 0; i < N; i++) m[i] = IW'($urandom_range(15));
      end
      e = ref_gather(d, m);
      if ($urandom_range(3) == 0) idle("rand_gap");
      drive(1'b0, 1'b1, d, m, e, ref_perm_err(m));
      tick("rand");
    end
    idle("final_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prepare_for_fft.md
Name: prepare_for_fft

Overview:
- Registered sample-reordering (gather) stage at the front of the FFT datapath.
- Takes a frame of SAMPLES parallel samples and a per-position index map, and produces output_stream[i] = input_stream[new_indices[i]].
- Upstream stage-ordering logic supplies the index map, e.g. the butterfly pairing pattern 0,8,1,9,2,10,… for a 16-point stage.
- One clock, synchronous active-high reset, valid-qualified frames, fixed one-cycle latency.

Parameters:
- SAMPLES, 16: frame length; must be a power of two and ≥ 2.
- WIDTH, 3: bits per sample.
- IDXW, $clog2(SAMPLES): index width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  frame on input_stream/new_indices is valid this cycle.
- input_stream  input  WIDTH x SAMPLES (unpacked array)  input samples.
- new_indices  input  IDXW x SAMPLES (unpacked array)  source index for each output position.
- out_valid  output  1  output_stream holds a valid permuted frame.
- output_stream  output  WIDTH x SAMPLES (unpacked array)  permuted samples.
- perm_error  output  1  captured new_indices was not a permutation (see Optional Feature).

Behaviour:
- Reset: on a rising clk with rst=1, out_valid=0, every output_stream element=0, perm_error=0. rst has priority over in_valid.
- Capture: on a rising clk with rst=0 and in_valid=1, for every i in 0..SAMPLES-1, output_stream[i] <= input_stream[new_indices[i]]. Same edge: out_valid <= 1.
- Hold: on a rising clk with rst=0 and in_valid=0, out_valid <= 0. output_stream and perm_error hold their last values, with no spurious change.
- Latency: exactly 1 cycle from the in_valid edge to out_valid.
- Throughput: one frame per cycle. Back-to-back in_valid keeps out_valid=1, and each cycle shows the frame captured on the previous edge.
- No backpressure: there is no ready signal, and the consumer must accept out_valid frames as they arrive.
- Index range: SAMPLES is a power of two, so every IDXW-bit index is in range.
- Duplicate indices are legal for the datapath: the same source is copied to several outputs. Missing indices are simply dropped.
- Identity map (new_indices[i]=i) passes the frame through unchanged.
- Purely combinational select inside; no arithmetic on sample values, so WIDTH is preserved exactly.
- Reset asserted mid-stream: the frame in flight is discarded, and the next out_valid requires a new in_valid after rst deasserts.

Optional Feature:
- Macro PREPARE_FOR_FFT_PERM_CHECK_EN.
- When defined:
  - On each capture, perm_error <= 1 if any source index 0..SAMPLES-1 is absent from new_indices, i.e. duplicates exist; otherwise 0.
  - perm_error is registered alongside output_stream and is valid whenever out_valid=1.
  - The datapath output is unaffected.
- When undefined: perm_error is tied to constant 0 and no checking logic is synthesized.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and random data -> out_valid=0, all output_stream=0, perm_error=0.
- Butterfly map:
  - Stimulus: SAMPLES=16, WIDTH=3, input_stream[i]=i%8, new_indices=[0,8,1,9,2,10,3,11,4,12,5,13,6,14,7,15], one-cycle in_valid.
  - Response: next cycle out_valid=1 and output_stream=[0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7]; the cycle after, out_valid=0 with data held.
- Identity and reversal:
  - Stimulus: input_stream[i]=i%8, new_indices[i]=i, then new_indices[i]=15-i on back-to-back cycles.
  - Response: out_valid stays 1 for 2 cycles; outputs are [0..7,0..7], then [7,6,…,0,7,6,…,0].
- Duplicate map:
  - Stimulus: all new_indices=5, input_stream[5]=6.
  - Response: every output_stream element=6; perm_error=1 with PREPARE_FOR_FFT_PERM_CHECK_EN defined, 0 without.
- Reset mid-stream: in_valid=1 for 3 cycles, with rst=1 on the 2nd edge -> out_valid=1, then 0 with outputs cleared, then 1 with the 3rd frame.
